// File: rtl/video_pkg.sv
// Shared constants and helpers for the raster timing / test-pattern generator.
package video_pkg;

  // Pattern selector encodings; 5-7 fall back to solid.
  localparam logic [2:0] MODE_SOLID    = 3'd0;
  localparam logic [2:0] MODE_BARS     = 3'd1;
  localparam logic [2:0] MODE_CHECKER  = 3'd2;
  localparam logic [2:0] MODE_GRADIENT = 3'd3;
  localparam logic [2:0] MODE_IMAGE    = 3'd4;

  // One bit per component: a set bit means that component is fully on.
  typedef struct packed {
    logic g;
    logic r;
    logic b;
  } bar_rgb_t;

  // Bar index modulo 8 maps straight onto the {G,R,B} bit pattern.
  function automatic bar_rgb_t bar_color(input int idx);
    logic [31:0] v;
    v = idx;
    return bar_rgb_t'(v[2:0]);
  endfunction

  // Full period of one axis: active plus porches plus sync.
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width large enough for 0 .. max(h_total, v_total)-1.
  function automatic int ctr_width(input int h_total, input int v_total);
    int m;
    m = (h_total > v_total) ? h_total : v_total;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster x/y counters with sync/data-enable decode and first-pixel flag.
module video_timing_core
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1365,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 24,
  parameter int H_BP     = 18,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 3,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] x_next,
  output logic [CW-1:0] y_next,
  output logic          de_raw,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          first_px
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_width_check
    $error("video_timing_core: counter width too small for raster totals");
  end

  logic [31:0] x32;
  logic [31:0] y32;

  assign x32 = 32'(x);
  assign y32 = 32'(y);

  // Next raster position; a low enable parks the raster at the origin.
  always_comb begin
    x_next = x;
    y_next = y;
    if (!enable) begin
      x_next = '0;
      y_next = '0;
    end else if (x32 == 32'(H_TOTAL - 1)) begin
      x_next = '0;
      y_next = (y32 == 32'(V_TOTAL - 1)) ? '0 : y + CW'(1);
    end else begin
      x_next = x + CW'(1);
    end
  end

  // Stage-0 position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

  // Timing decode from the current position; vertical sync spans whole lines.
  always_comb begin
    de_raw   = (x32 < 32'(H_ACTIVE)) && (y32 < 32'(V_ACTIVE));
    hs_raw   = (x32 >= 32'(H_ACTIVE + H_FP)) && (x32 < 32'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw   = (y32 >= 32'(V_ACTIVE + V_FP)) && (y32 < 32'(V_ACTIVE + V_FP + V_SYNC));
    first_px = (x == '0) && (y == '0);
  end

endmodule

// File: rtl/video_pattern_timing_gen.sv
// Raster timing plus five-mode test-pattern source with a 2-cycle output pipeline.
module video_pattern_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = 1365,
  parameter int H_FP      = 8,
  parameter int H_SYNC    = 24,
  parameter int H_BP      = 18,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 3,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int COLOR_W   = 8,
  parameter int BAR_COUNT = 8,
  parameter int CHK_LOG2  = 4,
  parameter int IMG_W     = 102,
  parameter int IMG_H     = 102,
  parameter int IMG_AW    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [IMG_AW-1:0]    img_addr,
  input  logic [3*COLOR_W-1:0] img_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CW      = ctr_width(H_TOTAL, V_TOTAL);
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int BAR_W   = H_ACTIVE / BAR_COUNT;
  localparam int BIW     = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;
  localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  if (IMG_W * IMG_H > (1 << IMG_AW)) begin : g_img_check
    $error("video_pattern_timing_gen: image window does not fit IMG_AW");
  end
  if (BAR_W < 1 || CHK_LOG2 > 31) begin : g_pat_check
    $error("video_pattern_timing_gen: bar/checker parameters out of range");
  end

  logic [CW-1:0]      x, y, x_next, y_next;
  logic               de_raw, hs_raw, vs_raw, first_px;
  logic [31:0]        x32, y32;
  logic               latch_now, in_win, next_in_win, use_img;
  logic [2:0]         mode_reg, mode_eff;
  logic [RGB_W-1:0]   solid_reg, solid_eff;
  logic [COLOR_W-1:0] frame_reg, frame_eff;
  logic [BIW-1:0]     bar_idx_reg;
  logic [BCW-1:0]     bar_cnt_reg;
  logic [2:0]         bar_bits;
  logic [RGB_W-1:0]   bar_rgb, pat_rgb, rgb1_reg, rgb_reg;
  logic               de1_reg, hs1_reg, vs1_reg, fs1_reg, img1_reg;
  bar_rgb_t           bc;

  video_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_core (
    .clk(clk), .rst(rst), .enable(enable),
    .x(x), .y(y), .x_next(x_next), .y_next(y_next),
    .de_raw(de_raw), .hs_raw(hs_raw), .vs_raw(vs_raw), .first_px(first_px)
  );

  assign x32         = 32'(x);
  assign y32         = 32'(y);
  assign in_win      = (x32 < 32'(IMG_W)) && (y32 < 32'(IMG_H));
  assign next_in_win = (32'(x_next) < 32'(IMG_W)) && (32'(y_next) < 32'(IMG_H));

  // Frame-wide settings switch on the first pixel itself, so the whole frame sees them.
  always_comb begin
    latch_now = enable && first_px;
    mode_eff  = latch_now ? mode : mode_reg;
    solid_eff = latch_now ? solid_rgb : solid_reg;
    frame_eff = latch_now ? frame_reg + COLOR_W'(1) : frame_reg;
  end

  // Mode/colour latch and frame counter, updated once per frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg  <= MODE_SOLID;
      solid_reg <= '0;
      frame_reg <= '0;
    end else if (latch_now) begin
      mode_reg  <= mode;
      solid_reg <= solid_rgb;
      frame_reg <= frame_reg + COLOR_W'(1);
    end
  end

  // Bar index tracks x; remainder pixels stay in the saturated last bar.
  always_ff @(posedge clk) begin
    if (rst || x_next == '0) begin
      bar_idx_reg <= '0;
      bar_cnt_reg <= '0;
    end else if (bar_cnt_reg == BCW'(BAR_W - 1)) begin
      bar_cnt_reg <= '0;
      if (bar_idx_reg != BIW'(BAR_COUNT - 1)) bar_idx_reg <= bar_idx_reg + BIW'(1);
    end else begin
      bar_cnt_reg <= bar_cnt_reg + BCW'(1);
    end
  end

  // Image address follows the next position so memory data lines up one cycle later.
  always_ff @(posedge clk) begin
    if (rst || (x_next == '0 && y_next == '0)) img_addr <= '0;
    else if (next_in_win) img_addr <= img_addr + IMG_AW'(1);
  end

  assign bc       = bar_color(int'(bar_idx_reg));
  assign bar_bits = {bc.r, bc.g, bc.b};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_bar_comp
    assign bar_rgb[gi*COLOR_W +: COLOR_W] = {COLOR_W{bar_bits[gi]}};
  end

  // Stage-0 pattern selection; image mode defers the colour to the memory read.
  always_comb begin
    pat_rgb = solid_eff;
    use_img = 1'b0;
    case (mode_eff)
      MODE_BARS:     pat_rgb = bar_rgb;
      MODE_CHECKER:  pat_rgb = {RGB_W{x32[CHK_LOG2] ^ y32[CHK_LOG2]}};
      MODE_GRADIENT: pat_rgb = {x32[COLOR_W-1:0], y32[COLOR_W-1:0], frame_eff};
      MODE_IMAGE:    use_img = in_win;
      default:       pat_rgb = solid_eff;
    endcase
  end

  // Stage 1: decoded timing and pattern, forced inactive while disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      de1_reg  <= 1'b0;
      hs1_reg  <= 1'b0;
      vs1_reg  <= 1'b0;
      fs1_reg  <= 1'b0;
      img1_reg <= 1'b0;
      rgb1_reg <= '0;
    end else begin
      de1_reg  <= de_raw;
      hs1_reg  <= hs_raw;
      vs1_reg  <= vs_raw;
      fs1_reg  <= first_px;
      img1_reg <= use_img;
      rgb1_reg <= pat_rgb;
    end
  end

  // Stage 2: output registers with polarity applied and blanking outside de.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      rgb_reg     <= '0;
    end else begin
      de          <= de1_reg;
      hsync       <= hs1_reg ? HS_POL : ~HS_POL;
      vsync       <= vs1_reg ? VS_POL : ~VS_POL;
      frame_start <= fs1_reg;
      rgb_reg     <= !de1_reg ? '0 : (img1_reg ? img_data : rgb1_reg);
    end
  end

  assign red   = rgb_reg[3*COLOR_W-1:2*COLOR_W];
  assign green = rgb_reg[2*COLOR_W-1:COLOR_W];
  assign blue  = rgb_reg[COLOR_W-1:0];

endmodule

// File: tb/tb_video_pattern_timing_gen.sv
// Directed bench on a 16x8 active raster (24x12 total) with a 4x4 image window.
module tb_video_pattern_timing_gen;

  localparam int HT = 24;  // clocks per line in this configuration

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic [23:0] solid_rgb = 24'h000000;
  logic [13:0] img_addr;
  logic [23:0] img_data = 24'h0;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red, green, blue;
  logic [23:0] rgb;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  // Image memory model with 1-cycle read latency; data equals address.
  always_ff @(posedge clk) img_data <= 24'(img_addr);

  video_pattern_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .BAR_COUNT(8),
    .CHK_LOG2(2), .IMG_W(4), .IMG_H(4), .IMG_AW(14)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .img_addr(img_addr), .img_data(img_data),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [23:0] solid;
    int          px;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] m, input logic [23:0] s, input int xx, input int yy,
                              input logic d, input logic h, input logic v, input logic [23:0] c);
    vec_t r;
    r.mode = m; r.solid = s; r.px = yy * HT + xx;
    r.de = d; r.hs = h; r.vs = v; r.rgb = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse reset; on return we sit at a negedge with the raster at the origin.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_cnt = 0;
  endtask

  // Outputs show stage-0 pixel k after the (k+2)-th edge from the origin.
  task automatic advance_to_pixel(input int k);
    while (edge_cnt < k + 2) begin
      @(posedge clk);
      edge_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int de_cnt, vs_low, hs_low, hs_low_l0, hs_first, de_l0, rgb_bad;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset de", 32'(de), 32'd0);
    check("reset rgb", 32'(rgb), 32'd0);
    check("reset hsync", 32'(hsync), 32'd1);
    check("reset vsync", 32'(vsync), 32'd1);
    check("reset frame_start", 32'(frame_start), 32'd0);
    check("reset img_addr", 32'(img_addr), 32'd0);

    // Directed vector table: {mode, solid, x, y, de, hsync, vsync, rgb}
    vecs.push_back(mk(3'd0, 24'h123456,  0,  0, 1, 1, 1, 24'h123456));
    vecs.push_back(mk(3'd0, 24'h123456, 15,  0, 1, 1, 1, 24'h123456));
    vecs.push_back(mk(3'd0, 24'h123456, 16,  0, 0, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456, 17,  0, 0, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456, 18,  0, 0, 0, 1, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456, 20,  0, 0, 0, 1, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456, 21,  0, 0, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456,  7,  7, 1, 1, 1, 24'h123456));
    vecs.push_back(mk(3'd0, 24'h123456,  0,  8, 0, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456,  0,  9, 0, 1, 0, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456,  5, 10, 0, 1, 0, 24'h000000));
    vecs.push_back(mk(3'd0, 24'h123456,  0, 11, 0, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd1, 24'h123456,  0,  0, 1, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd1, 24'h123456,  1,  0, 1, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd1, 24'h123456,  2,  0, 1, 1, 1, 24'h0000FF));
    vecs.push_back(mk(3'd1, 24'h123456,  5,  1, 1, 1, 1, 24'hFF0000));
    vecs.push_back(mk(3'd1, 24'h123456,  7,  0, 1, 1, 1, 24'hFF00FF));
    vecs.push_back(mk(3'd1, 24'h123456,  9,  2, 1, 1, 1, 24'h00FF00));
    vecs.push_back(mk(3'd1, 24'h123456, 11,  0, 1, 1, 1, 24'h00FFFF));
    vecs.push_back(mk(3'd1, 24'h123456, 13,  0, 1, 1, 1, 24'hFFFF00));
    vecs.push_back(mk(3'd1, 24'h123456, 14,  3, 1, 1, 1, 24'hFFFFFF));
    vecs.push_back(mk(3'd1, 24'h123456, 16,  0, 0, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd2, 24'h123456,  0,  0, 1, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd2, 24'h123456,  4,  0, 1, 1, 1, 24'hFFFFFF));
    vecs.push_back(mk(3'd2, 24'h123456,  4,  4, 1, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd2, 24'h123456,  3,  5, 1, 1, 1, 24'hFFFFFF));
    vecs.push_back(mk(3'd3, 24'h123456,  5,  3, 1, 1, 1, 24'h050301));
    vecs.push_back(mk(3'd3, 24'h123456, 15,  7, 1, 1, 1, 24'h0F0701));
    vecs.push_back(mk(3'd4, 24'hA0B0C0,  0,  0, 1, 1, 1, 24'h000000));
    vecs.push_back(mk(3'd4, 24'hA0B0C0,  3,  0, 1, 1, 1, 24'h000003));
    vecs.push_back(mk(3'd4, 24'hA0B0C0,  4,  0, 1, 1, 1, 24'hA0B0C0));
    vecs.push_back(mk(3'd4, 24'hA0B0C0,  2,  1, 1, 1, 1, 24'h000006));
    vecs.push_back(mk(3'd4, 24'hA0B0C0,  1,  2, 1, 1, 1, 24'h000009));
    vecs.push_back(mk(3'd4, 24'hA0B0C0,  3,  3, 1, 1, 1, 24'h00000F));
    vecs.push_back(mk(3'd4, 24'hA0B0C0,  0,  4, 1, 1, 1, 24'hA0B0C0));
    vecs.push_back(mk(3'd4, 24'hA0B0C0, 15,  7, 1, 1, 1, 24'hA0B0C0));
    vecs.push_back(mk(3'd5, 24'h654321,  3,  3, 1, 1, 1, 24'h654321));

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      solid_rgb = vecs[i].solid;
      do_reset();
      advance_to_pixel(vecs[i].px);
      check($sformatf("vec%0d de", i), 32'(de), 32'(vecs[i].de));
      check($sformatf("vec%0d hsync", i), 32'(hsync), 32'(vecs[i].hs));
      check($sformatf("vec%0d vsync", i), 32'(vsync), 32'(vecs[i].vs));
      check($sformatf("vec%0d rgb", i), 32'(rgb), 32'(vecs[i].rgb));
      $display("[TB] vec %0d mode=%0d px=%0d de=%0b hs=%0b vs=%0b rgb=%06h",
               i, vecs[i].mode, vecs[i].px, de, hsync, vsync, rgb);
    end

    // Whole-frame timing measurement in solid mode
    mode = 3'd0; solid_rgb = 24'h123456;
    do_reset();
    de_cnt = 0; vs_low = 0; hs_low = 0; hs_low_l0 = 0; hs_first = -1; de_l0 = 0; rgb_bad = 0;
    for (int k = 0; k < 12 * HT; k++) begin
      advance_to_pixel(k);
      if (de) de_cnt++;
      if (!vsync) vs_low++;
      if (!hsync) hs_low++;
      if (k < HT && !hsync) begin
        hs_low_l0++;
        if (hs_first < 0) hs_first = k;
      end
      if (k < HT && de) de_l0++;
      if (de && rgb !== 24'h123456) rgb_bad++;
    end
    check("frame de count", 32'(de_cnt), 32'd128);
    check("frame vsync low", 32'(vs_low), 32'd48);
    check("frame hsync low", 32'(hs_low), 32'd36);
    check("line0 hsync low", 32'(hs_low_l0), 32'd3);
    check("line0 hsync start", 32'(hs_first), 32'd18);
    check("line0 de count", 32'(de_l0), 32'd16);
    check("frame solid rgb", 32'(rgb_bad), 32'd0);
    $display("[TB] frame de=%0d vs_low=%0d hs_low=%0d hs_first=%0d", de_cnt, vs_low, hs_low, hs_first);

    // Mode change bars -> checker mid-frame
    mode = 3'd1; solid_rgb = 24'h123456;
    do_reset();
    advance_to_pixel(50);
    mode = 3'd2;
    advance_to_pixel(6 * HT + 4);
    check("midframe still bars", 32'(rgb), 32'hFF0000);
    advance_to_pixel(12 * HT - 1);
    check("pre-frame frame_start", 32'(frame_start), 32'd0);
    advance_to_pixel(12 * HT);
    check("next frame_start", 32'(frame_start), 32'd1);
    advance_to_pixel(12 * HT + 2);
    check("checker at (2,0)", 32'(rgb), 32'h000000);
    advance_to_pixel(12 * HT + 4);
    check("checker at (4,0)", 32'(rgb), 32'hFFFFFF);
    $display("[TB] mode change sequence done");

    // Reset asserted mid-line
    mode = 3'd0; solid_rgb = 24'h123456;
    do_reset();
    advance_to_pixel(5);
    check("pre-rst de", 32'(de), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst de", 32'(de), 32'd0);
    check("midrst rgb", 32'(rgb), 32'd0);
    check("midrst hsync", 32'(hsync), 32'd1);
    check("midrst vsync", 32'(vsync), 32'd1);
    rst = 1'b0;
    edge_cnt = 0;
    advance_to_pixel(-1);
    check("post-rst fs early", 32'(frame_start), 32'd0);
    advance_to_pixel(0);
    check("post-rst frame_start", 32'(frame_start), 32'd1);
    advance_to_pixel(1);
    check("post-rst fs pulse", 32'(frame_start), 32'd0);
    advance_to_pixel(17);
    check("post-rst hsync x17", 32'(hsync), 32'd1);
    advance_to_pixel(18);
    check("post-rst hsync x18", 32'(hsync), 32'd0);
    $display("[TB] mid-line reset sequence done");

    // Enable dropped for 5 clocks in gradient mode
    mode = 3'd3;
    do_reset();
    advance_to_pixel(3 * HT + 5);
    check("grad frame1", 32'(rgb), 32'h050301);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("disable +1 de", 32'(de), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("disable +2 de", 32'(de), 32'd0);
    check("disable +2 hsync", 32'(hsync), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("disable +5 rgb", 32'(rgb), 32'd0);
    enable = 1'b1;
    edge_cnt = 0;
    advance_to_pixel(-1);
    check("reenable fs early", 32'(frame_start), 32'd0);
    advance_to_pixel(0);
    check("reenable frame_start", 32'(frame_start), 32'd1);
    advance_to_pixel(3 * HT + 5);
    check("grad frame2", 32'(rgb), 32'h050302);
    $display("[TB] enable gap sequence done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
